// File: rtl/skew_shift_array_if.sv
// Bus bundle for skew_shift_array: packed lane input/output, shared beat valid,
// stall enable, synchronous flush and in-flight status.
interface skew_shift_array_if #(
  parameter int DW    = 8,
  parameter int LANES = 4
);
  logic [LANES*DW-1:0] din;
  logic                din_vld;
  logic                en;
  logic                clr;
  logic [LANES*DW-1:0] dout;
  logic [LANES-1:0]    dout_vld;
  logic                busy;

  modport master (
    output din, din_vld, en, clr,
    input  dout, dout_vld, busy
  );

  modport slave (
    input  din, din_vld, en, clr,
    output dout, dout_vld, busy
  );
endinterface

// File: rtl/skew_shift_array.sv
// Multi-lane input-skew buffer: lane i delays its beats by BASE_DLY+i+1 enabled cycles.
// Build macro SKEW_DESKEW_EN mirrors the delays (lane LANES-1 shortest) for output deskew.
module skew_shift_array #(
  parameter int DW       = 8,
  parameter int LANES    = 4,
  parameter int BASE_DLY = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  skew_shift_array_if.slave  bus
);

  logic [LANES-1:0] lane_busy;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
`ifdef SKEW_DESKEW_EN
    localparam int D = BASE_DLY + (LANES - 1 - g) + 1;
`else
    localparam int D = BASE_DLY + g + 1;
`endif

    logic [DW-1:0] dat_q [D];
    logic [DW-1:0] dat_d [D];
    logic [D-1:0]  vld_q;
    logic [D-1:0]  vld_d;

    // Data is forced to zero alongside a cleared valid so idle stages always read 0.
    always_comb begin
      dat_d = dat_q;
      vld_d = vld_q;
      if (bus.clr) begin
        for (int k = 0; k < D; k++) dat_d[k] = '0;
        vld_d = '0;
      end else if (bus.en) begin
        vld_d[0] = bus.din_vld;
        dat_d[0] = bus.din_vld ? bus.din[g*DW +: DW] : '0;
        for (int k = 1; k < D; k++) begin
          dat_d[k] = dat_q[k-1];
          vld_d[k] = vld_q[k-1];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < D; k++) dat_q[k] <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign bus.dout[g*DW +: DW] = dat_q[D-1];
    assign bus.dout_vld[g]      = vld_q[D-1];
    assign lane_busy[g]         = |vld_q;
  end

  assign bus.busy = |lane_busy;

endmodule
